mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: BURST, default 4, legal 1..15; maximum consecutive cycles one requester holds the shared mux per grant.
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: RST  input  1  reset; synchronous, active-high.
REQ-004 Port: REQ  input  8  request lines; bit i = requester i wants the mux.
REQ-005 Port: GNT  output  8  one-hot grant to requester; all-zero when idle.
REQ-006 Port: SEL  output  3  select to 8:1 mux; index of granted requester.
REQ-007 Port: EN_N  output  1  active-low mux enable; 0 only while a grant is held.
REQ-008 Port: BUSY  output  1  1 while in GRANT state.

Function
REQ-009 The block SHALL implement two states, IDLE and GRANT; all outputs SHALL be registered.
REQ-010 The block SHALL keep a 3-bit rotating pointer PTR giving the highest-priority index; search order PTR, PTR+1, ... mod 8.
REQ-011 In IDLE with REQ nonzero at edge k, the block SHALL assert GNT/SEL for the first set bit in search order, EN_N=0, BUSY=1, state GRANT, after edge k (one-cycle latency).
REQ-012 In IDLE with REQ=0, the block SHALL hold GNT=0, EN_N=1, BUSY=0, and SEL unchanged.
REQ-013 On grant, a 4-bit burst counter SHALL load BURST-1; it SHALL decrement each GRANT cycle the holder keeps its request.
REQ-014 Release SHALL occur at an edge where REQ[SEL]=0 or counter=0; on release PTR SHALL become SEL+1 mod 8 (7 wraps to 0).
REQ-015 On release, if any REQ bit is set, the block SHALL grant the next winner, searching from SEL+1 mod 8, at the same edge with no idle cycle; a sole persistent requester SHALL be re-granted.
REQ-016 On release with REQ=0, the block SHALL return to IDLE: GNT=0, EN_N=1, BUSY=0.
REQ-017 GNT SHALL always be zero or one-hot and equal to (EN_N==0) ? (1<<SEL) : 0.
REQ-018 Requests arriving mid-grant SHALL NOT preempt the holder.
REQ-019 With BURST=1, every grant SHALL last exactly one cycle.

Reset
REQ-020 RST=1 at an edge SHALL force IDLE, GNT=0, SEL=0, EN_N=1, BUSY=0, PTR=0, counter=0, including mid-grant; REQ is ignored while RST=1.
REQ-021 The first arbitration SHALL occur at the first edge with RST=0.

Configuration
REQ-022 Macro MUX_RR_ARBITER_STATS_EN, when defined, SHALL add output GRANT_CNT [15:0], reset 0, incremented once per new grant (including back-to-back re-grants), wrapping 0xFFFF->0.
REQ-023 Without MUX_RR_ARBITER_STATS_EN, the GRANT_CNT port and its logic SHALL be absent.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE, GRANT), the requester count (8), and the select width (3).
REQ-025 The rotating priority search SHALL be a combinational sub-module rr_pick (inputs REQ, PTR; outputs valid, index).

Verification
REQ-026 Reset: RST=1 two cycles with REQ=8'hFF -> GNT=0, EN_N=1, SEL=0, BUSY=0.
REQ-027 Single request: REQ=8'h08 held from IDLE -> one cycle later SEL=3, GNT=8'h08, EN_N=0; with BURST=4, releases after 4 cycles and re-grants SEL=3 with no gap.
REQ-028 Round robin: REQ=8'hFF constant, BURST=1 -> SEL sequence 0,1,2,...,7,0 with one grant per cycle and EN_N constantly 0.
REQ-029 Early drop: grant to 5, REQ[5] drops after 2 cycles, REQ=8'h21 -> next grant is index 0 (wrap past 7), PTR=6.
REQ-030 Reset mid-grant: RST=1 during a grant to index 6 -> next edge GNT=0, EN_N=1; after release, REQ=8'h41 grants index 0 first.
REQ-031 Stats build: 10 single-cycle grants -> GRANT_CNT=10; reset returns it to 0.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared state encoding and sizing for the round-robin mux arbiter
package mux_rr_arbiter_pkg;
  localparam int NREQ = 8;
  localparam int SELW = 3;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority search, first set request at or after ptr
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [SELW-1:0] ptr,
  output logic            valid,
  output logic [SELW-1:0] index
);
  logic [NREQ-1:0] rot;
  logic [SELW-1:0] off;
  // rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) off = rot[i] ? SELW'(i) : off;
    valid = |req;
    index = ptr + off;
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving an 8:1 mux select; MUX_RR_ARBITER_STATS_EN adds GRANT_CNT
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int BURST = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [SELW-1:0] SEL,
  output logic            EN_N,
  output logic            BUSY
`ifdef MUX_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]     GRANT_CNT
`endif
);
  localparam logic [3:0] CNT_LOAD = 4'(BURST - 1);
  state_t          state, state_nx;
  logic [SELW-1:0] ptr, start, sel_nx, pick_i;
  logic [3:0]      cnt, cnt_nx;
  logic            pick_v, rel, arb;
  // after a release the search resumes just past the holder; from idle it starts at ptr
  assign start = (state == GRANT) ? SEL + 3'd1 : ptr;
  assign rel   = (state == GRANT) && (!REQ[SEL] || cnt == 4'd0);
  assign arb   = (state == IDLE) || rel;
  rr_pick u_pick (
    .req  (REQ),
    .ptr  (start),
    .valid(pick_v),
    .index(pick_i)
  );
  // next state: arbitrate when idle or releasing, otherwise count down the holder's burst
  always_comb begin
    state_nx = arb ? (pick_v ? GRANT : IDLE) : state;
    sel_nx   = (arb && pick_v) ? pick_i : SEL;
    cnt_nx   = arb ? (pick_v ? CNT_LOAD : 4'd0) : cnt - 4'd1;
  end
  // state and registered mux-facing outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      SEL   <= '0;
      GNT   <= '0;
      EN_N  <= 1'b1;
      BUSY  <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= arb ? start : ptr;
      cnt   <= cnt_nx;
      SEL   <= sel_nx;
      GNT   <= (state_nx == GRANT) ? NREQ'(1) << sel_nx : '0;
      EN_N  <= state_nx != GRANT;
      BUSY  <= state_nx == GRANT;
    end
  end
`ifdef MUX_RR_ARBITER_STATS_EN
  // count every new grant, including back-to-back re-grants; wraps naturally
  always_ff @(posedge CLK) begin
    if (RST) GRANT_CNT <= '0;
    else GRANT_CNT <= GRANT_CNT + 16'(arb && pick_v);
  end
`endif
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed pins plus randomized traffic against a behavioural arbiter model
module tb_mux_rr_arbiter;
  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] REQ = 8'hFF;
  logic [7:0] gnt [2];
  logic [2:0] sel [2];
  logic       en_n [2];
  logic       busy [2];
  logic [15:0] gcnt [2];
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  int m_busy [2], m_sel [2], m_held [2], m_ptr [2], m_gc [2];

  always #5 clk = ~clk;

  mux_rr_arbiter #(.BURST(4)) u4 (
    .CLK(clk), .RST(RST), .REQ(REQ), .GNT(gnt[0]), .SEL(sel[0]), .EN_N(en_n[0]), .BUSY(busy[0])
`ifdef MUX_RR_ARBITER_STATS_EN
    , .GRANT_CNT(gcnt[0])
`endif
  );
  mux_rr_arbiter #(.BURST(1)) u1 (
    .CLK(clk), .RST(RST), .REQ(REQ), .GNT(gnt[1]), .SEL(sel[1]), .EN_N(en_n[1]), .BUSY(busy[1])
`ifdef MUX_RR_ARBITER_STATS_EN
    , .GRANT_CNT(gcnt[1])
`endif
  );

  function automatic int bu(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int first_from(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: holder keeps the mux while requesting and under its burst, else hand over round-robin
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        m_busy[k] = 0; m_sel[k] = 0; m_held[k] = 0; m_ptr[k] = 0; m_gc[k] = 0;
      end else if (m_busy[k] != 0 && REQ[m_sel[k]] && m_held[k] < bu(k)) begin
        m_held[k]++;
      end else begin
        int w;
        if (m_busy[k] != 0) m_ptr[k] = (m_sel[k] + 1) % 8;
        w = first_from(REQ, m_ptr[k]);
        m_busy[k] = (w >= 0) ? 1 : 0;
        if (w >= 0) begin
          m_sel[k] = w; m_held[k] = 1; m_gc[k] = (m_gc[k] + 1) % 65536;
        end
      end
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("mdl_gnt", 16'(gnt[k]), (m_busy[k] != 0) ? 16'(1 << m_sel[k]) : 16'd0);
        chk("mdl_sel", 16'(sel[k]), 16'(m_sel[k]));
        chk("mdl_en_n", 16'(en_n[k]), 16'(m_busy[k] == 0));
        chk("mdl_busy", 16'(busy[k]), 16'(m_busy[k] != 0));
`ifdef MUX_RR_ARBITER_STATS_EN
        chk("mdl_gcnt", gcnt[k], 16'(m_gc[k]));
`endif
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    armed = 1'b1;
    chk("rst_gnt", 16'(gnt[0]), 16'h0);
    chk("rst_en_n", 16'(en_n[0]), 16'h1);
    chk("rst_sel", 16'(sel[0]), 16'h0);
    chk("rst_busy", 16'(busy[0]), 16'h0);
    RST = 1'b0; REQ = 8'h08;
    @(negedge clk);
    chk("single_sel", 16'(sel[0]), 16'h3);
    chk("single_gnt", 16'(gnt[0]), 16'h08);
    chk("single_en_n", 16'(en_n[0]), 16'h0);
    repeat (6) begin
      @(negedge clk);
      chk("single_regrant_en_n", 16'(en_n[0]), 16'h0);
      chk("single_regrant_sel", 16'(sel[0]), 16'h3);
    end
    RST = 1'b1; REQ = 8'hFF;
    @(negedge clk);
    RST = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rr_sel", 16'(sel[1]), 16'(i % 8));
      chk("rr_en_n", 16'(en_n[1]), 16'h0);
    end
    RST = 1'b1; REQ = 8'h20;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk("drop_first", 16'(sel[0]), 16'h5);
    REQ = 8'h21;
    @(negedge clk);
    chk("drop_nopreempt", 16'(sel[0]), 16'h5);
    REQ = 8'h01;
    @(negedge clk);
    chk("drop_wrap_sel", 16'(sel[0]), 16'h0);
    chk("drop_wrap_gnt", 16'(gnt[0]), 16'h01);
    chk("drop_ptr", 16'(u4.ptr), 16'h6);
    RST = 1'b1; REQ = 8'h40;
    @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk("midrst_sel6", 16'(sel[0]), 16'h6);
    RST = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 16'(gnt[0]), 16'h0);
    chk("midrst_en_n", 16'(en_n[0]), 16'h1);
    RST = 1'b0; REQ = 8'h41;
    @(negedge clk);
    chk("midrst_first", 16'(sel[0]), 16'h0);
`ifdef MUX_RR_ARBITER_STATS_EN
    RST = 1'b1; REQ = 8'hFF;
    @(negedge clk);
    RST = 1'b0;
    repeat (10) @(negedge clk);
    chk("stats_ten", gcnt[1], 16'd10);
    RST = 1'b1;
    @(negedge clk);
    chk("stats_rst", gcnt[1], 16'd0);
`endif
    RST = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0: REQ = 8'h00;
          1: REQ = 8'(1 << $urandom_range(0, 7));
          2: REQ = 8'($urandom);
          default: REQ = 8'($urandom & $urandom);
        endcase
      end
      RST = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    RST = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
